// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder, the sum accumulator and the result consumer.
// slave = accumulator view, master = producer/consumer (bench) view.
interface sum_accumulator_if #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned ACC_WIDTH = 8
) ();
    logic [WIDTH:0]       sum_in;
    logic                 sum_valid;
    logic                 sum_ready;
    logic [ACC_WIDTH-1:0] acc_out;
    logic                 acc_valid;
    logic                 acc_ready;
    logic                 ovf;

    modport slave (
        input  sum_in, sum_valid, acc_ready,
        output sum_ready, acc_out, acc_valid, ovf
    );

    modport master (
        output sum_in, sum_valid, acc_ready,
        input  sum_ready, acc_out, acc_valid, ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates NSAMP accepted adder sums into a window total presented on a valid/ready output.
// Optional feature macro: SUM_ACC_SATURATE_EN (clamp accumulator to all-ones on carry out).
module sum_accumulator #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned NSAMP     = 4,
    parameter int unsigned ACC_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    sum_accumulator_if.slave   bus
);
    localparam int unsigned        CNT_W    = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(NSAMP - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_ONES = {ACC_WIDTH{1'b1}};

    typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t               state_q,     state_d;
    logic [ACC_WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic                 win_ovf_q,   win_ovf_d;
    logic [ACC_WIDTH-1:0] acc_out_q,   acc_out_d;
    logic                 ovf_q,       ovf_d;
    logic                 acc_valid_q, acc_valid_d;
    logic                 sum_ready_q, sum_ready_d;

    logic [ACC_WIDTH:0]   add_s;
    logic                 add_ovf_s;
    logic [ACC_WIDTH-1:0] acc_new_s;

    assign add_s     = {1'b0, acc_q} + {{(ACC_WIDTH - WIDTH){1'b0}}, bus.sum_in};
    assign add_ovf_s = win_ovf_q | add_s[ACC_WIDTH];

    // Next accumulator value: wrap or clamp once the window has overflowed
    always_comb begin
        acc_new_s = add_s[ACC_WIDTH-1:0];
`ifdef SUM_ACC_SATURATE_EN
        if (add_ovf_s) begin
            acc_new_s = ACC_ONES;
        end else begin
            acc_new_s = add_s[ACC_WIDTH-1:0];
        end
`else
        if (add_ovf_s) begin
            acc_new_s = add_s[ACC_WIDTH-1:0];
        end else begin
            acc_new_s = add_s[ACC_WIDTH-1:0];
        end
`endif
    end

    // Next-state and output-register decode
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        win_ovf_d   = win_ovf_q;
        acc_out_d   = acc_out_q;
        ovf_d       = ovf_q;
        acc_valid_d = acc_valid_q;
        if (clear_i) begin
            state_d     = ACCUM;
            acc_d       = {ACC_WIDTH{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
            win_ovf_d   = 1'b0;
            acc_out_d   = {ACC_WIDTH{1'b0}};
            ovf_d       = 1'b0;
            acc_valid_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.sum_valid && (cnt_q == LAST_CNT)) begin
                        acc_out_d   = acc_new_s;
                        ovf_d       = add_ovf_s;
                        acc_valid_d = 1'b1;
                        acc_d       = {ACC_WIDTH{1'b0}};
                        cnt_d       = {CNT_W{1'b0}};
                        win_ovf_d   = 1'b0;
                        state_d     = HOLD;
                    end else if (bus.sum_valid) begin
                        acc_d     = acc_new_s;
                        cnt_d     = cnt_q + CNT_W'(1'b1);
                        win_ovf_d = add_ovf_s;
                    end else begin
                        state_d = ACCUM;
                    end
                end
                HOLD: begin
                    // Returning to ACCUM here gives the one-cycle input bubble
                    if (bus.acc_ready) begin
                        acc_valid_d = 1'b0;
                        state_d     = ACCUM;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d     = ACCUM;
                    acc_valid_d = 1'b0;
                end
            endcase
        end
        sum_ready_d = (state_d == ACCUM);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ACCUM;
            acc_q       <= {ACC_WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            win_ovf_q   <= 1'b0;
            acc_out_q   <= {ACC_WIDTH{1'b0}};
            ovf_q       <= 1'b0;
            acc_valid_q <= 1'b0;
            sum_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            win_ovf_q   <= win_ovf_d;
            acc_out_q   <= acc_out_d;
            ovf_q       <= ovf_d;
            acc_valid_q <= acc_valid_d;
            sum_ready_q <= sum_ready_d;
        end
    end

    assign bus.sum_ready = sum_ready_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator (main, narrow-accumulator and NSAMP=1 instances).
module tb_sum_accumulator;
    logic clk;
    logic rst_n;
    logic clear;
    int   n_vec;
    int   n_err;

    sum_accumulator_if #(.WIDTH(4), .ACC_WIDTH(7)) bus7 ();
    sum_accumulator_if #(.WIDTH(4), .ACC_WIDTH(6)) bus6 ();
    sum_accumulator_if #(.WIDTH(4), .ACC_WIDTH(7)) bus1 ();

    sum_accumulator #(.WIDTH(4), .NSAMP(4), .ACC_WIDTH(7)) dut7 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus7));
    sum_accumulator #(.WIDTH(4), .NSAMP(4), .ACC_WIDTH(6)) dut6 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus6));
    sum_accumulator #(.WIDTH(4), .NSAMP(1), .ACC_WIDTH(7)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample for a single edge, then idle; starts and ends 1 time unit after an edge
    task automatic feed7(input logic [4:0] v, input int idle);
        bus7.sum_in    = v;
        bus7.sum_valid = 1'b1;
        @(posedge clk); #1;
        bus7.sum_valid = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
    endtask

    task automatic feed6(input logic [4:0] v);
        bus6.sum_in    = v;
        bus6.sum_valid = 1'b1;
        @(posedge clk); #1;
        bus6.sum_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out} !== {1'b0, 1'b0, 1'b1, 7'd0}) begin
            n_err++; $display("FAIL reset_initial: got %h want %h",
                {bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out}, {1'b0, 1'b0, 1'b1, 7'd0});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        feed7(5'd5, 0);
        feed7(5'd5, 0);
        bus7.sum_in = 5'd5; bus7.sum_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out} !== {1'b0, 1'b0, 1'b1, 7'd0}) begin
            n_err++; $display("FAIL reset_async: got %h want %h",
                {bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out}, {1'b0, 1'b0, 1'b1, 7'd0});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out} !== {1'b0, 1'b0, 1'b1, 7'd0}) begin
            n_err++; $display("FAIL reset_held: got %h want %h",
                {bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out}, {1'b0, 1'b0, 1'b1, 7'd0});
        end
        bus7.sum_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) feed7(5'd1, 0);
        n_vec++;
        if ({bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out} !== {1'b1, 1'b0, 1'b0, 7'd4}) begin
            n_err++; $display("FAIL reset_no_residue: got %h want %h",
                {bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out}, {1'b1, 1'b0, 1'b0, 7'd4});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        feed7(5'd3, 0);
        feed7(5'd5, 0);
        feed7(5'd7, 0);
        n_vec++;
        if (bus7.acc_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_early_valid: got %b want 0", bus7.acc_valid);
        end
        feed7(5'd9, 0);
        n_vec++;
        if ({bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out} !== {1'b1, 1'b0, 1'b0, 7'd24}) begin
            n_err++; $display("FAIL b2b_result: got %h want %h",
                {bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out}, {1'b1, 1'b0, 1'b0, 7'd24});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({bus7.acc_valid, bus7.sum_ready} !== 2'b01) begin
            n_err++; $display("FAIL b2b_release: got %b want 01", {bus7.acc_valid, bus7.sum_ready});
        end
    endtask

    task automatic test_hold();
        bus7.acc_ready = 1'b0;
        feed7(5'd3, 0); feed7(5'd5, 0); feed7(5'd7, 0); feed7(5'd9, 0);
        bus7.sum_in = 5'd2; bus7.sum_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out} !== {1'b1, 1'b0, 1'b0, 7'd24}) begin
                n_err++; $display("FAIL hold_stable[%0d]: got %h want %h", i,
                    {bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out}, {1'b1, 1'b0, 1'b0, 7'd24});
            end
        end
        bus7.acc_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({bus7.acc_valid, bus7.sum_ready} !== 2'b01) begin
            n_err++; $display("FAIL hold_release: got %b want 01", {bus7.acc_valid, bus7.sum_ready});
        end
        repeat (3) begin @(posedge clk); #1; end
        n_vec++;
        if (bus7.acc_valid !== 1'b0) begin
            n_err++; $display("FAIL hold_no_sample_taken: got %b want 0", bus7.acc_valid);
        end
        @(posedge clk); #1;
        bus7.sum_valid = 1'b0;
        n_vec++;
        if ({bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out} !== {1'b1, 1'b0, 1'b0, 7'd8}) begin
            n_err++; $display("FAIL hold_next_window: got %h want %h",
                {bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out}, {1'b1, 1'b0, 1'b0, 7'd8});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        feed7(5'd1, 0);
        feed7(5'd2, 2);
        feed7(5'd3, 3);
        feed7(5'd4, 0);
        n_vec++;
        if ({bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out} !== {1'b1, 1'b0, 1'b0, 7'd10}) begin
            n_err++; $display("FAIL gaps_result: got %h want %h",
                {bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out}, {1'b1, 1'b0, 1'b0, 7'd10});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        logic [5:0] exp_ovf;
`ifdef SUM_ACC_SATURATE_EN
        exp_ovf = 6'd63;
`else
        exp_ovf = 6'd56;
`endif
        for (int i = 0; i < 4; i++) feed6(5'd30);
        n_vec++;
        if ({bus6.acc_valid, bus6.ovf, bus6.sum_ready, bus6.acc_out} !== {1'b1, 1'b1, 1'b0, exp_ovf}) begin
            n_err++; $display("FAIL ovf_result: got %h want %h",
                {bus6.acc_valid, bus6.ovf, bus6.sum_ready, bus6.acc_out}, {1'b1, 1'b1, 1'b0, exp_ovf});
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) feed6(5'd1);
        n_vec++;
        if ({bus6.acc_valid, bus6.ovf, bus6.sum_ready, bus6.acc_out} !== {1'b1, 1'b0, 1'b0, 6'd4}) begin
            n_err++; $display("FAIL ovf_next_window: got %h want %h",
                {bus6.acc_valid, bus6.ovf, bus6.sum_ready, bus6.acc_out}, {1'b1, 1'b0, 1'b0, 6'd4});
        end
        @(posedge clk); #1;
        bus6.acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed6(5'd30);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        bus6.acc_ready = 1'b1;
        n_vec++;
        if ({bus6.acc_valid, bus6.ovf, bus6.sum_ready, bus6.acc_out} !== {1'b0, 1'b0, 1'b1, 6'd0}) begin
            n_err++; $display("FAIL clear_in_hold: got %h want %h",
                {bus6.acc_valid, bus6.ovf, bus6.sum_ready, bus6.acc_out}, {1'b0, 1'b0, 1'b1, 6'd0});
        end
    endtask

    task automatic test_clear();
        feed7(5'd6, 0);
        feed7(5'd6, 0);
        bus7.sum_in = 5'd9; bus7.sum_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        bus7.sum_valid = 1'b0; clear = 1'b0;
        n_vec++;
        if ({bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out} !== {1'b0, 1'b0, 1'b1, 7'd0}) begin
            n_err++; $display("FAIL clear_state: got %h want %h",
                {bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out}, {1'b0, 1'b0, 1'b1, 7'd0});
        end
        for (int i = 0; i < 4; i++) feed7(5'd1, 0);
        n_vec++;
        if ({bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out} !== {1'b1, 1'b0, 1'b0, 7'd4}) begin
            n_err++; $display("FAIL clear_next_window: got %h want %h",
                {bus7.acc_valid, bus7.ovf, bus7.sum_ready, bus7.acc_out}, {1'b1, 1'b0, 1'b0, 7'd4});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nsamp1();
        bus1.sum_in = 5'd5; bus1.sum_valid = 1'b1;
        @(posedge clk); #1;
        bus1.sum_valid = 1'b0;
        n_vec++;
        if ({bus1.acc_valid, bus1.ovf, bus1.sum_ready, bus1.acc_out} !== {1'b1, 1'b0, 1'b0, 7'd5}) begin
            n_err++; $display("FAIL nsamp1_first: got %h want %h",
                {bus1.acc_valid, bus1.ovf, bus1.sum_ready, bus1.acc_out}, {1'b1, 1'b0, 1'b0, 7'd5});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({bus1.acc_valid, bus1.sum_ready} !== 2'b01) begin
            n_err++; $display("FAIL nsamp1_release: got %b want 01", {bus1.acc_valid, bus1.sum_ready});
        end
        bus1.sum_in = 5'd31; bus1.sum_valid = 1'b1;
        @(posedge clk); #1;
        bus1.sum_valid = 1'b0;
        n_vec++;
        if ({bus1.acc_valid, bus1.ovf, bus1.sum_ready, bus1.acc_out} !== {1'b1, 1'b0, 1'b0, 7'd31}) begin
            n_err++; $display("FAIL nsamp1_second: got %h want %h",
                {bus1.acc_valid, bus1.ovf, bus1.sum_ready, bus1.acc_out}, {1'b1, 1'b0, 1'b0, 7'd31});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        bus7.sum_in = 5'd0; bus7.sum_valid = 1'b0; bus7.acc_ready = 1'b1;
        bus6.sum_in = 5'd0; bus6.sum_valid = 1'b0; bus6.acc_ready = 1'b1;
        bus1.sum_in = 5'd0; bus1.sum_valid = 1'b0; bus1.acc_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_hold();
        test_gaps();
        test_overflow();
        test_clear();
        test_nsamp1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
